// File: rtl/sme_ctrl.sv
// sme_ctrl: buffers string/pattern records, replays them to a string-matching engine and returns its result
// Ports: clk/reset (async active-low); in_* requester byte stream (valid/ready, data, type, last);
//        sme_chardata/sme_isstring/sme_ispattern byte stream to the engine; sme_valid/sme_match/
//        sme_match_index engine result; res_* result handshake (valid/ready, match, index, status).
module sme_ctrl #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_type,
  input  logic       in_last,
  output logic [7:0] sme_chardata,
  output logic       sme_isstring,
  output logic       sme_ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic [1:0] res_status
);
  localparam int BUF = STR_MAX > PAT_MAX ? STR_MAX : PAT_MAX;
  localparam int AW = BUF > 1 ? $clog2(BUF) : 1;
  localparam int LW = $clog2(BUF + 1);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;
  logic [2:0] state;
  logic [7:0] mem [BUF];
  logic [LW-1:0] len, pidx, lim;
  logic [AW-1:0] waddr;
  logic [CW-1:0] cnt;
  logic typ, trunc, loaded, str_trunc, up, cur_typ, xfer, room;
  // up keeps in_ready low until the first edge after reset release
  assign in_ready = up && (state == S_IDLE || state == S_FILL);
  assign xfer = in_valid && in_ready;
  // in IDLE the record type comes straight from the first byte
  assign cur_typ = state == S_IDLE ? in_type : typ;
  assign lim = cur_typ ? LW'(PAT_MAX) : LW'(STR_MAX);
  assign room = state == S_IDLE || len < lim;
  assign waddr = state == S_IDLE ? '0 : len[AW-1:0];
  assign res_valid = state == S_RESP;
  always_ff @(posedge clk)
    if (xfer && room) mem[waddr] <= in_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      up <= 1'b0;
      len <= '0;
      pidx <= '0;
      cnt <= '0;
      typ <= 1'b0;
      trunc <= 1'b0;
      loaded <= 1'b0;
      str_trunc <= 1'b0;
      sme_chardata <= '0;
      sme_isstring <= 1'b0;
      sme_ispattern <= 1'b0;
      res_match <= 1'b0;
      res_index <= '0;
      res_status <= '0;
    end else begin
      up <= 1'b1;
      case (state)
        S_IDLE, S_FILL: if (xfer) begin
          if (state == S_IDLE) begin
            len <= LW'(1);
            trunc <= 1'b0;
            typ <= in_type;
          end else if (room) len <= len + 1'b1;
          else trunc <= 1'b1;
          if (!in_last) state <= S_FILL;
          else if (cur_typ && !loaded) begin
            state <= S_RESP;
            res_match <= 1'b0;
            res_index <= '0;
            res_status <= 2'b10;
          end else begin
            state <= S_PLAY;
            pidx <= '0;
          end
        end
        S_PLAY: if (pidx == len) begin
          sme_isstring <= 1'b0;
          sme_ispattern <= 1'b0;
          if (typ) begin
            state <= S_WAIT;
            cnt <= '0;
          end else begin
            state <= S_IDLE;
            loaded <= 1'b1;
            str_trunc <= trunc;
          end
        end else begin
          sme_chardata <= mem[pidx[AW-1:0]];
          sme_isstring <= !typ;
          sme_ispattern <= typ;
          pidx <= pidx + 1'b1;
        end
        S_WAIT: if (sme_valid) begin
          state <= S_RESP;
          res_match <= sme_match;
          res_index <= sme_match ? sme_match_index : '0;
          res_status <= (trunc || str_trunc) ? 2'b11 : 2'b00;
        end else if (cnt == CW'(TIMEOUT)) begin
          state <= S_RESP;
          res_match <= 1'b0;
          res_index <= '0;
          res_status <= 2'b01;
        end else cnt <= cnt + 1'b1;
        S_RESP: if (res_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule
